// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Input stage for the front-panel buttons of the seven-segment animation top.
// Each raw button is synchronised with two flops, then qualified by its own
// four-state debounce FSM. For every channel the block delivers a debounced
// level plus single-cycle press and release pulses. All outputs are
// registered, and the channels are fully independent of each other.
//
// Optional feature (macro BTN_AUTOREPEAT_EN):
//   When defined, a held button produces extra btn_press pulses. The first
//   repeat comes REPEAT_DELAY cycles after the press is accepted, and later
//   repeats follow every REPEAT_RATE cycles. When undefined, each accepted
//   press yields exactly one btn_press and no repeat counters are built.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   btn_raw      raw asynchronous buttons, active high      [NUM_BTN]
//   btn_level    debounced button state                     [NUM_BTN]
//   btn_press    one-cycle pulse on accepted press/repeat   [NUM_BTN]
//   btn_release  one-cycle pulse on accepted release        [NUM_BTN]
// -----------------------------------------------------------------------------
module btn_conditioner #(
    parameter int NUM_BTN      = 4,
    parameter int DEBOUNCE_BIT = 16,
    parameter int DEBOUNCE_VAL = 20000,
    parameter int REPEAT_BIT   = 24,
    parameter int REPEAT_DELAY = 5_000_000,
    parameter int REPEAT_RATE  = 2_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CONF_ON  = 2'd1,
        S_PRESSED  = 2'd2,
        S_CONF_OFF = 2'd3
    } state_t;

    localparam logic [DEBOUNCE_BIT-1:0] CNT_LAST = DEBOUNCE_BIT'(DEBOUNCE_VAL - 1);

    // Two-flop synchroniser; only r_sync2 is used by the FSMs.
    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifndef BTN_AUTOREPEAT_EN
    // Repeat parameters only matter when auto-repeat is built.
    logic w_unused_rpt_cfg;
    assign w_unused_rpt_cfg = (REPEAT_BIT + REPEAT_DELAY + REPEAT_RATE) != 0;
`endif

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        state_t                  r_state;
        state_t                  w_state_nxt;
        logic [DEBOUNCE_BIT-1:0] r_cnt;
        logic [DEBOUNCE_BIT-1:0] w_cnt_nxt;
        logic                    w_press_nxt;
        logic                    w_release_nxt;
        logic                    w_rpt_fire;
        logic                    r_level;
        logic                    r_press;
        logic                    r_release;
        logic                    w_sync;

        assign w_sync = r_sync2[g];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state   <= S_IDLE;
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_level   <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_CONF_OFF);
                r_press   <= w_press_nxt | w_rpt_fire;
                r_release <= w_release_nxt;
            end
        end

        // A disagreement with the current level must persist for DEBOUNCE_VAL
        // confirmation cycles; any bounce returns to the stable state and the
        // counter is cleared on every state exit, so it can never wrap.
        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sync) begin
                        w_state_nxt = S_CONF_ON;
                        w_cnt_nxt   = '0;
                    end
                end
                S_CONF_ON: begin
                    if (!w_sync) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + DEBOUNCE_BIT'(1);
                    end
                end
                S_PRESSED: begin
                    if (!w_sync) begin
                        w_state_nxt = S_CONF_OFF;
                        w_cnt_nxt   = '0;
                    end
                end
                S_CONF_OFF: begin
                    if (w_sync) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_LAST) begin
                        w_state_nxt   = S_IDLE;
                        w_cnt_nxt     = '0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + DEBOUNCE_BIT'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

`ifdef BTN_AUTOREPEAT_EN
        localparam logic [REPEAT_BIT-1:0] RPT_DELAY_LAST = REPEAT_BIT'(REPEAT_DELAY - 1);
        localparam logic [REPEAT_BIT-1:0] RPT_RATE_LAST  = REPEAT_BIT'(REPEAT_RATE - 1);

        logic [REPEAT_BIT-1:0] r_rpt_cnt;
        logic                  r_rpt_armed;   // first repeat already issued
        logic                  w_rpt_run;

        // The counter only runs while the channel stays in PRESSED; a release
        // bounce passes through CONF_OFF, which restarts the initial delay.
        assign w_rpt_run  = (r_state == S_PRESSED) && w_sync;
        assign w_rpt_fire = w_rpt_run &&
                            (r_rpt_cnt == (r_rpt_armed ? RPT_RATE_LAST : RPT_DELAY_LAST));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_rpt_cnt   <= '0;
                r_rpt_armed <= 1'b0;
            end else if (w_rpt_fire) begin
                r_rpt_cnt   <= '0;
                r_rpt_armed <= 1'b1;
            end else if (w_rpt_run) begin
                r_rpt_cnt   <= r_rpt_cnt + REPEAT_BIT'(1);
            end else begin
                r_rpt_cnt   <= '0;
                r_rpt_armed <= 1'b0;
            end
        end
`else
        assign w_rpt_fire = 1'b0;
`endif

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;
    end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

    localparam int NB = 4;
    localparam int DV = 4;
    localparam int RD = 10;
    localparam int RR = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;

    always #5 clk = ~clk;

    btn_conditioner #(
        .NUM_BTN     (NB),
        .DEBOUNCE_BIT(8),
        .DEBOUNCE_VAL(DV),
        .REPEAT_BIT  (8),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a button's accepted level changes once the synchronised
    // input (raw delayed by two samples) has disagreed with it for DV+1
    // consecutive samples. Repeats are counted in samples spent held steady.
    logic [NB-1:0] m_h1, m_h2;
    logic [NB-1:0] m_level, m_press, m_release;
    int            m_run  [NB];
    int            m_held [NB];

    function automatic void model_reset();
        m_h1 = '0; m_h2 = '0;
        m_level = '0; m_press = '0; m_release = '0;
        for (int i = 0; i < NB; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
        end
    endfunction

    function automatic void model_step(input logic [NB-1:0] raw);
        logic [NB-1:0] s;
        s    = m_h2;
        m_h2 = m_h1;
        m_h1 = raw;
        m_press   = '0;
        m_release = '0;
        for (int i = 0; i < NB; i++) begin
            if (s[i] != m_level[i]) begin
                m_held[i] = 0;
                m_run[i]  = m_run[i] + 1;
                if (m_run[i] == DV + 1) begin
                    m_level[i] = s[i];
                    m_run[i]   = 0;
                    if (s[i]) m_press[i] = 1'b1;
                    else      m_release[i] = 1'b1;
                end
            end else begin
                if (m_level[i] && m_run[i] == 0) begin
                    m_held[i] = m_held[i] + 1;
`ifdef BTN_AUTOREPEAT_EN
                    if (m_held[i] == RD || (m_held[i] > RD && (m_held[i] - RD) % RR == 0))
                        m_press[i] = 1'b1;
`endif
                end else begin
                    m_held[i] = 0;
                end
                m_run[i] = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("level",   32'(btn_level),   32'(m_level));
        chk("press",   32'(btn_press),   32'(m_press));
        chk("release", 32'(btn_release), 32'(m_release));
        chk("press_and_release", 32'(btn_press & btn_release), 32'd0);
    endtask

    // Drive one raw sample, clock it in, advance the model, compare after the edge.
    task automatic tick(input logic [NB-1:0] v);
        btn_raw = v;
        @(posedge clk);
        model_step(v);
        #1;
        check_outputs();
    endtask

    initial begin
        int            first;
        int            cnt_dut;
        int            cnt_mdl;
        logic          saw;
        logic [NB-1:0] v;
        logic [7:0]    bounce;

        reset   = 1'b1;
        btn_raw = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_level",   32'(btn_level),   32'd0);
        chk("reset_press",   32'(btn_press),   32'd0);
        chk("reset_release", 32'(btn_release), 32'd0);
        reset = 1'b0;
        repeat (4) tick('0);

        // Clean press / release on channel 0.
        first = -1;
        for (int k = 0; k < 20; k++) begin
            tick(4'b0001);
            if (btn_press[0] && first < 0) first = k;
        end
        chk("clean_press_edge", 32'(first), 32'd6);
        chk("clean_level", 32'(btn_level[0]), 32'd1);
        first = -1;
        for (int k = 0; k < 12; k++) begin
            tick(4'b0000);
            if (btn_release[0] && first < 0) first = k;
        end
        chk("clean_release_edge", 32'(first), 32'd6);

        // Press bounce on channel 2: 1,1,1,0 then steady high.
        bounce  = 8'b1111_0111;
        cnt_dut = 0;
        first   = -1;
        for (int k = 0; k < 8; k++) begin
            tick({1'b0, bounce[k], 2'b00});
            if (btn_press[2]) cnt_dut++;
            if (btn_press[2] && first < 0) first = k;
        end
        for (int k = 8; k < 16; k++) begin
            tick(4'b0100);
            if (btn_press[2]) cnt_dut++;
            if (btn_press[2] && first < 0) first = k;
        end
        chk("bounce_press_count", 32'(cnt_dut), 32'd1);
        chk("bounce_press_edge", 32'(first), 32'd10);
        repeat (12) tick('0);

        // Release bounce on channel 1.
        repeat (10) tick(4'b0010);
        saw = 1'b0;
        repeat (3) begin
            tick(4'b0000);
            saw = saw | btn_release[1] | ~btn_level[1];
        end
        repeat (8) begin
            tick(4'b0010);
            saw = saw | btn_release[1] | ~btn_level[1];
        end
        chk("release_bounce_quiet", 32'(saw), 32'd0);
        repeat (12) tick('0);

        // Simultaneous press on channels 0 and 3.
        saw = 1'b0;
        repeat (10) begin
            tick(4'b1001);
            if (btn_press == 4'b1001) saw = 1'b1;
        end
        chk("simultaneous_press", 32'(saw), 32'd1);
        repeat (12) tick('0);

        // Long hold on channel 2 for auto-repeat.
        cnt_dut = 0;
        cnt_mdl = 0;
        for (int k = 0; k < 52; k++) begin
            tick(k < 40 ? 4'b0100 : 4'b0000);
            if (btn_press[2]) cnt_dut++;
            if (m_press[2])   cnt_mdl++;
        end
`ifdef BTN_AUTOREPEAT_EN
        chk("hold_press_count", 32'(cnt_dut), 32'(cnt_mdl));
`else
        chk("hold_press_count", 32'(cnt_dut), 32'd1);
`endif

        // Reset asserted mid-cycle with all buttons held.
        repeat (10) tick(4'hF);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_level",   32'(btn_level),   32'd0);
        chk("async_reset_press",   32'(btn_press),   32'd0);
        chk("async_reset_release", 32'(btn_release), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        first = -1;
        for (int k = 0; k < 9; k++) begin
            tick(4'hF);
            if (btn_press == 4'hF && first < 0) first = k;
        end
        chk("post_reset_press_edge", 32'(first), 32'd6);
        chk("post_reset_level", 32'(btn_level), 32'hF);
        repeat (12) tick('0);

        // Randomised stimulus: short toggles (glitches) then longer holds.
        v = '0;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(5, 0) == 0) v[i] = ~v[i];
            tick(v);
        end
        for (int k = 0; k < 1200; k++) begin
            for (int i = 0; i < NB; i++)
                if ($urandom_range(29, 0) == 0) v[i] = ~v[i];
            tick(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
